// File: rtl/qlf_shchain_ctrl.sv
// qlf_shchain_ctrl
// Sequencer for an external serial chain of CHAIN_LEN shift-register flops.
// A parallel word is taken on the in_valid/in_ready handshake and shifted into
// the chain head, MSB first. The bits falling out of the chain tail are
// captured at the same time and returned as a parallel word on the
// out_valid/out_ready handshake. Rotate mode feeds the tail back into the
// head, so the chain is read without being disturbed.
//
// Ports:
//   C          clock, all state updates on the rising edge
//   R          asynchronous active-low reset
//   in_valid   request carries a word to load
//   in_ready   controller can accept a request (IDLE)
//   in_data    word to load, bit k lands in chain stage k (0 = head)
//   in_rot     sampled with the request, 1 = rotate, in_data ignored
//   sh_en      chain advances on each rising edge of C where this is 1
//   sh_d       serial data into the chain head
//   sh_q       serial data from the chain tail (stage CHAIN_LEN-1)
//   out_valid  out_data holds the captured chain contents
//   out_ready  consumer accepts out_data
//   out_data   previous chain contents, same indexing as in_data
//   busy       controller is not IDLE
module qlf_shchain_ctrl #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 C,
  input  logic                 R,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHAIN_LEN-1:0] in_data,
  input  logic                 in_rot,
  output logic                 sh_en,
  output logic                 sh_d,
  input  logic                 sh_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHAIN_LEN-1:0] out_data,
  output logic                 busy
);

  localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t               state, state_nxt;
  logic [CHAIN_LEN-1:0] sr, sr_nxt;
  logic                 rot, rot_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 sh_en_nxt;
  logic                 out_valid_nxt;
  logic [CHAIN_LEN-1:0] out_data_nxt;
  logic [CHAIN_LEN-1:0] cap_next;

  // Capture shifter: the tail bit seen on each shift edge enters at bit 0, so
  // after CHAIN_LEN edges the first captured bit (the old tail) sits at the
  // top. A one-flop chain needs no history, the word is just sh_q.
  generate
    if (CHAIN_LEN == 1) begin : g_single
      assign cap_next = sh_q;
    end else begin : g_multi
      logic [CHAIN_LEN-2:0] cap;

      // Only the lower CHAIN_LEN-1 captured bits need storing; the newest bit
      // is taken straight from sh_q on the final edge.
      always_ff @(posedge C or negedge R) begin
        if (!R) begin
          cap <= '0;
        end else if (state == SHIFT) begin
          cap <= cap_next[CHAIN_LEN-2:0];
        end
      end

      assign cap_next = {cap, sh_q};
    end
  endgenerate

  // State and registered outputs. sh_en is a flop so that reset drops it
  // asynchronously and stops the chain immediately.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state     <= IDLE;
      sr        <= '0;
      rot       <= 1'b0;
      cnt       <= '0;
      sh_en     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      rot       <= rot_nxt;
      cnt       <= cnt_nxt;
      sh_en     <= sh_en_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  // Next-state logic plus the combinational outputs. sh_d is only driven
  // while shifting; in rotate mode the tail is looped straight back.
  always_comb begin
    state_nxt     = state;
    sr_nxt        = sr;
    rot_nxt       = rot;
    cnt_nxt       = cnt;
    sh_en_nxt     = sh_en;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    in_ready      = 1'b0;
    busy          = 1'b1;
    sh_d          = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          sr_nxt    = in_data;
          rot_nxt   = in_rot;
          cnt_nxt   = '0;
          sh_en_nxt = 1'b1;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        sh_d    = rot ? sh_q : sr[CHAIN_LEN-1];
        sr_nxt  = sr << 1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          sh_en_nxt     = 1'b0;
          out_data_nxt  = cap_next;
          out_valid_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_qlf_shchain_ctrl.sv
// tb_qlf_shchain_ctrl
// Bench for qlf_shchain_ctrl with two instances: CHAIN_LEN=8 and CHAIN_LEN=1.
// Each instance drives a simple external chain of flops. The expected results
// come from a word-level model of the chain contents: a load returns the old
// word and replaces it, a rotate returns the old word and keeps it.
module tb_qlf_shchain_ctrl;

  logic C = 1'b0;
  logic R = 1'b1;

  int checks = 0;
  int errors = 0;

  // CHAIN_LEN = 8 instance
  logic       in_valid8 = 1'b0, in_rot8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] in_data8 = 8'h00;
  logic       in_ready8, sh_en8, sh_d8, sh_q8, out_valid8, busy8;
  logic [7:0] out_data8;
  logic [7:0] chain8 = 8'h00;
  logic [7:0] model8 = 8'h00;

  // CHAIN_LEN = 1 instance
  logic       in_valid1 = 1'b0, in_rot1 = 1'b0, out_ready1 = 1'b0;
  logic [0:0] in_data1 = 1'b0;
  logic       in_ready1, sh_en1, sh_d1, sh_q1, out_valid1, busy1;
  logic [0:0] out_data1;
  logic       chain1 = 1'b0;
  logic       model1 = 1'b0;

  always #5 C = ~C;

  qlf_shchain_ctrl #(.CHAIN_LEN(8)) dut8 (
    .C(C), .R(R),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_rot(in_rot8),
    .sh_en(sh_en8), .sh_d(sh_d8), .sh_q(sh_q8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .busy(busy8)
  );

  qlf_shchain_ctrl #(.CHAIN_LEN(1)) dut1 (
    .C(C), .R(R),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_rot(in_rot1),
    .sh_en(sh_en1), .sh_d(sh_d1), .sh_q(sh_q1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .busy(busy1)
  );

  // External chains: head is stage 0, tail feeds sh_q. They are not reset.
  always @(posedge C) begin
    if (sh_en8) chain8 <= {chain8[6:0], sh_d8};
    if (sh_en1) chain1 <= sh_d1;
  end

  assign sh_q8 = chain8[7];
  assign sh_q1 = chain1;

  // One complete transaction on the 8-bit instance, checked step by step.
  task automatic txn8(input logic [7:0] data, input logic rot, input int hold,
                      input bit chk_out, input string tag);
    logic [7:0] exp_out;
    logic [7:0] exp_seq;
    logic [7:0] held;
    int         waited;
    exp_out = model8;
    exp_seq = rot ? model8 : data;
    waited  = 0;
    while (in_ready8 !== 1'b1 && waited < 50) begin
      @(negedge C);
      waited++;
    end
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s accept: in_ready got %b expected 1", tag, in_ready8);
    end
    in_valid8 = 1'b1;
    in_data8  = data;
    in_rot8   = rot;
    @(negedge C);
    for (int i = 0; i < 8; i++) begin
      in_valid8 = 1'($urandom);
      in_data8  = 8'($urandom);
      in_rot8   = 1'($urandom);
      checks++;
      if ({sh_en8, sh_d8, busy8, in_ready8, out_valid8} !== {1'b1, exp_seq[7-i], 3'b100}) begin
        errors++;
        $display("[TB] FAIL %s shift %0d: sh_en,sh_d,busy,in_ready,out_valid got %b expected %b",
                 tag, i, {sh_en8, sh_d8, busy8, in_ready8, out_valid8}, {1'b1, exp_seq[7-i], 3'b100});
      end
      @(negedge C);
    end
    checks++;
    if ({out_valid8, sh_en8, sh_d8, in_ready8} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL %s done: out_valid,sh_en,sh_d,in_ready got %b expected 1000",
               tag, {out_valid8, sh_en8, sh_d8, in_ready8});
    end
    if (chk_out) begin
      checks++;
      if (out_data8 !== exp_out) begin
        errors++;
        $display("[TB] FAIL %s out_data: got %h expected %h", tag, out_data8, exp_out);
      end
    end
    held = chk_out ? exp_out : out_data8;
    for (int i = 0; i < hold; i++) begin
      in_valid8 = 1'($urandom);
      in_data8  = 8'($urandom);
      checks++;
      if ({out_valid8, in_ready8, sh_en8, sh_d8, busy8} !== 5'b10001 || out_data8 !== held) begin
        errors++;
        $display("[TB] FAIL %s hold %0d: flags got %b expected 10001, out_data got %h expected %h",
                 tag, i, {out_valid8, in_ready8, sh_en8, sh_d8, busy8}, out_data8, held);
      end
      @(negedge C);
    end
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    @(negedge C);
    out_ready8 = 1'b0;
    checks++;
    if ({out_valid8, in_ready8, busy8} !== 3'b010 || out_data8 !== held) begin
      errors++;
      $display("[TB] FAIL %s handshake: out_valid,in_ready,busy got %b expected 010, out_data got %h expected %h",
               tag, {out_valid8, in_ready8, busy8}, out_data8, held);
    end
    if (!rot) model8 = data;
  endtask

  // One complete transaction on the single-flop instance.
  task automatic txn1(input logic d, input logic rot, input int hold, input string tag);
    logic exp_out;
    logic exp_d;
    int   waited;
    exp_out = model1;
    exp_d   = rot ? model1 : d;
    waited  = 0;
    while (in_ready1 !== 1'b1 && waited < 50) begin
      @(negedge C);
      waited++;
    end
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s accept: in_ready got %b expected 1", tag, in_ready1);
    end
    in_valid1 = 1'b1;
    in_data1  = d;
    in_rot1   = rot;
    @(negedge C);
    in_valid1 = 1'($urandom);
    checks++;
    if ({sh_en1, sh_d1, busy1, out_valid1} !== {1'b1, exp_d, 2'b10}) begin
      errors++;
      $display("[TB] FAIL %s shift: sh_en,sh_d,busy,out_valid got %b expected %b",
               tag, {sh_en1, sh_d1, busy1, out_valid1}, {1'b1, exp_d, 2'b10});
    end
    @(negedge C);
    checks++;
    if ({out_valid1, sh_en1, sh_d1} !== 3'b100 || out_data1 !== exp_out) begin
      errors++;
      $display("[TB] FAIL %s done: out_valid,sh_en,sh_d got %b expected 100, out_data got %b expected %b",
               tag, {out_valid1, sh_en1, sh_d1}, out_data1, exp_out);
    end
    for (int i = 0; i < hold; i++) @(negedge C);
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    @(negedge C);
    out_ready1 = 1'b0;
    checks++;
    if ({out_valid1, in_ready1, busy1} !== 3'b010 || out_data1 !== exp_out) begin
      errors++;
      $display("[TB] FAIL %s handshake: out_valid,in_ready,busy got %b expected 010, out_data got %b expected %b",
               tag, {out_valid1, in_ready1, busy1}, out_data1, exp_out);
    end
    if (!rot) model1 = d;
  endtask

  task automatic test_reset;
    #2 R = 1'b0;
    #1;
    checks++;
    if ({in_ready8, sh_en8, sh_d8, out_valid8, busy8} !== 5'b10000 || out_data8 !== 8'h00 ||
        {in_ready1, sh_en1, sh_d1, out_valid1, busy1} !== 5'b10000 || out_data1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: flags8 %b flags1 %b expected 10000, out_data8 %h out_data1 %b expected 0",
               {in_ready8, sh_en8, sh_d8, out_valid8, busy8}, {in_ready1, sh_en1, sh_d1, out_valid1, busy1},
               out_data8, out_data1);
    end
    repeat (2) @(negedge C);
    R = 1'b1;
  endtask

  task automatic test_load;
    txn8(8'hA5, 1'b0, 0, 1'b1, "load_a5");
    txn8(8'h3C, 1'b0, 0, 1'b1, "load_3c");
  endtask

  task automatic test_rotate;
    txn8(8'hFF, 1'b1, 0, 1'b1, "rotate_1");
    txn8(8'hFF, 1'b1, 1, 1'b1, "rotate_2");
  endtask

  task automatic test_backpressure;
    txn8(8'($urandom), 1'b0, 5, 1'b1, "backpressure");
  endtask

  task automatic test_reset_midop;
    in_valid8 = 1'b1;
    in_data8  = 8'h5A;
    in_rot8   = 1'b0;
    @(negedge C);
    in_valid8 = 1'b0;
    repeat (3) @(negedge C);
    #1 R = 1'b0;
    #1;
    checks++;
    if ({in_ready8, sh_en8, sh_d8, out_valid8, busy8} !== 5'b10000 || out_data8 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_midop: flags got %b expected 10000, out_data got %h expected 00",
               {in_ready8, sh_en8, sh_d8, out_valid8, busy8}, out_data8);
    end
    @(negedge C);
    R = 1'b1;
    txn8(8'h0F, 1'b0, 0, 1'b0, "after_reset_0f");
    txn8(8'h00, 1'b0, 0, 1'b1, "after_reset_00");
  endtask

  task automatic test_len1;
    txn1(1'b1, 1'b0, 0, "len1_load1");
    txn1(1'b0, 1'b0, 0, "len1_load0");
    for (int i = 0; i < 6; i++) txn1(1'($urandom), 1'($urandom), $urandom_range(0, 2), "len1_random");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      txn8(8'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b1, "random");
  endtask

  initial begin
    test_reset();
    test_load();
    test_rotate();
    test_backpressure();
    test_reset_midop();
    test_len1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qlf_shchain_ctrl.md
Name: qlf_shchain_ctrl

Overview:
- Sequencer for an external serial chain of CHAIN_LEN shift-register flops (sh_dff cells, clocked by C through a clock gate driven by sh_en).
- Accepts a parallel word on a valid/ready handshake and shifts it serially into the chain.
- Captures the bits shifted out of the chain tail and returns the previous chain contents as a parallel word on a second valid/ready handshake.
- A rotate mode reads the chain non-destructively.

Parameters:
CHAIN_LEN, 16, number of flops in the chain; legal range 1..1024
CNT_W, $clog2(CHAIN_LEN) with minimum 1 (derived, not overridable), shift counter width

Ports:
C  input  1  clock; all state updates on rising edge
R  input  1  reset, asynchronous, active-low
in_valid  input  1  request carries a word to load
in_ready  output  1  controller can accept a request
in_data  input  CHAIN_LEN  word to load; bit k lands in chain stage k (stage 0 = head, CHAIN_LEN-1 = tail)
in_rot  input  1  sampled with request; 1 = rotate (sh_d fed from sh_q), in_data ignored
sh_en  output  1  chain advances on each C rising edge where sh_en=1
sh_d  output  1  serial data into chain head
sh_q  input  1  serial data from chain tail (stage CHAIN_LEN-1)
out_valid  output  1  out_data holds captured chain contents
out_ready  input  1  consumer accepts out_data
out_data  output  CHAIN_LEN  previous chain contents, same indexing as in_data
busy  output  1  state != IDLE

Behaviour:
- Reset (R=0, asynchronous): state=IDLE, in_ready=1, sh_en=0, sh_d=0, out_valid=0, out_data=0, busy=0, cnt=0, shift/capture regs=0. Chain contents are not reset by this block.
- States: IDLE, SHIFT, DONE. All outputs are registered except in_ready, busy and sh_d, which are combinational from registers and sh_q.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: sr<=in_data, rot<=in_rot, cnt<=0, sh_en<=1, state<=SHIFT.
- SHIFT:
  - in_ready=0.
  - sh_d = rot ? sh_q : sr[CHAIN_LEN-1].
  - On each edge: cap<={cap[CHAIN_LEN-2:0], sh_q}, sr<=sr<<1, cnt<=cnt+1.
  - When cnt==CHAIN_LEN-1 on that edge: sh_en<=0, out_data<={cap[CHAIN_LEN-2:0], sh_q}, out_valid<=1, state<=DONE.
  - Exactly CHAIN_LEN chain-advancing edges per transaction. The first bit shifted is in_data[CHAIN_LEN-1]; the first bit captured is the old tail.
- DONE:
  - in_ready=0, sh_en=0, sh_d=0.
  - out_valid and out_data are held stable until an edge with out_ready=1; that edge sets out_valid<=0 and state<=IDLE.
  - out_data retains its value after the handshake.
  - No IDLE bypass: the next request is accepted at the earliest one cycle after the out handshake.
- Latency: request accepted at edge 0; shifts on edges 1..CHAIN_LEN; out_valid=1 after edge CHAIN_LEN.
- sh_d=0 whenever state != SHIFT.
- CHAIN_LEN=1: a single shift edge; cap is unused, out_data=sh_q sampled on that edge.
- in_valid while busy is ignored; the requester must hold it until in_ready.
- Reset mid-SHIFT aborts immediately, sh_en=0 asynchronously. The chain holds a partially shifted word (undefined to software). The next transaction proceeds normally.
- The counter never wraps: it is cleared on accept and compared against CHAIN_LEN-1.

Test Plan:
- Reset: assert R=0 mid-cycle -> in_ready=1, sh_en=0, sh_d=0, out_valid=0, out_data=0, busy=0 asynchronously.
- CHAIN_LEN=8, chain powers up 0:
  - load 0xA5 -> exactly 8 sh_en cycles, sh_d sequence 1,0,1,0,0,1,0,1, out_valid 8 cycles after accept, out_data=0x00.
  - then load 0x3C -> out_data=0xA5.
- Rotate: after chain=0x3C, request in_rot=1 with in_data=0xFF -> out_data=0x3C; repeat rotate -> out_data=0x3C again (chain unchanged).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, out_data stable, in_ready=0, sh_en=0, and in_valid ignored. Raise out_ready -> IDLE the next cycle.
- Reset mid-operation: assert R=0 after 3 shift edges -> all outputs at reset values. New load 0x0F then load 0x00 -> second out_data=0x0F.
- CHAIN_LEN=1: load 1 then load 0 -> one sh_en cycle each; second out_data=1.
